// File: rtl/ex_muldiv_unit.sv
// Iterative HI/LO multiply/divide unit beside the EX-stage ALU (radix-2, one bit per clock).
// Optional MULDIV_EARLY_OUT_EN: multiplies with a narrow multiplier finish in WIDTH/2 iterations.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic                 is_div, neg_q, neg_r, div0;

  logic                 start, mt, early;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       shifted, diff;
  logic [2*WIDTH-1:0]   mul_next;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic en);
    return en ? -x : x;
  endfunction

  assign busy  = (state != IDLE);
  assign stall = req && busy;
  assign start = req && !op[2] && !flush && (state == IDLE);
  assign mt    = req && (op[2:1] == 2'b11) && !flush && (state == IDLE);

  // Signed ops (even opcodes) work on magnitudes; signs are reapplied in FIX.
  assign a_neg = !op[0] && op_a[WIDTH-1];
  assign b_neg = !op[0] && op_b[WIDTH-1];
  assign mag_a = cond_neg(op_a, a_neg);
  assign mag_b = cond_neg(op_b, b_neg);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = !op[1] && (mag_b[WIDTH-1:WIDTH/2] == '0);
`else
  assign early = 1'b0;
`endif

  // Restoring divide step: remainder in acc upper half, dividend/quotient in lower half.
  assign shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign diff     = shifted - {1'b0, mcand};
  // Multiply consumes the multiplier MSB-first so an early-out needs no final shift.
  assign mul_next = {acc[2*WIDTH-2:0], 1'b0} + (mplier[WIDTH-1] ? {{WIDTH{1'b0}}, mcand} : '0);

  always_comb begin
    mf_data = '0;
    if (op == 3'd4) mf_data = hi;
    else if (op == 3'd5) mf_data = lo;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX) && !flush;
      if (start) begin
        cnt    <= early ? CNT_W'(WIDTH/2) : CNT_W'(WIDTH);
        is_div <= op[1];
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        div0   <= op[1] && (op_b == '0);
        mcand  <= op[1] ? mag_b : mag_a;
        mplier <= early ? (mag_b << (WIDTH/2)) : mag_b;
        acc    <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
      end else if (state == CALC && !flush) begin
        cnt    <= cnt - CNT_W'(1);
        mplier <= {mplier[WIDTH-2:0], 1'b0};
        if (is_div)
          acc <= {(diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                  acc[WIDTH-2:0], !diff[WIDTH]};
        else
          acc <= mul_next;
      end
      // FIX commit: sign correction, divide-by-zero forces an all-ones quotient.
      if (state == FIX && !flush) begin
        if (is_div) begin
          lo <= div0 ? '1 : cond_neg(acc[WIDTH-1:0], neg_q);
          hi <= cond_neg(acc[2*WIDTH-1:WIDTH], neg_r);
        end else begin
          {hi, lo} <= cond_neg2(acc, neg_q);
        end
      end else if (mt) begin
        if (op[0]) lo <= op_a;
        else       hi <= op_a;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (WIDTH=32).
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic        stall, busy, done;
  logic [31:0] mf_data, hi, lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .mf_data(mf_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_CYC = 17;
`else
  localparam int EARLY_CYC = 33;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc);
    int cyc;
    req = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    req = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      tick();
    end
    chk({tag, ".busy_cycles"}, 64'(cyc), 64'(ecyc));
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".hi"}, 64'(hi), 64'(eh));
    chk({tag, ".lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; req = 1'b0; op = 3'd0; op_a = '0; op_b = '0; flush = 1'b0;
    tick(); tick();
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    tick();

    // MTHI then MFHI
    req = 1'b1; op = 3'd6; op_a = 32'h1234;
    tick();
    chk("mthi.hi", 64'(hi), 64'h1234);
    chk("mthi.busy", 64'(busy), 64'd0);
    op = 3'd4; op_a = 32'h0;
    #1;
    chk("mfhi.data", 64'(mf_data), 64'h1234);
    chk("mfhi.stall", 64'(stall), 64'd0);
    tick();
    chk("mfhi.busy", 64'(busy), 64'd0);
    chk("mfhi.done", 64'(done), 64'd0);
    // MTLO then MFLO
    op = 3'd7; op_a = 32'h55;
    tick();
    op = 3'd5;
    #1;
    chk("mflo.data", 64'(mf_data), 64'h55);
    req = 1'b0;

    // flush with req in IDLE: request ignored
    req = 1'b1; op = 3'd0; op_a = 32'd3; op_b = 32'd4; flush = 1'b1;
    tick();
    chk("flush_idle.busy", 64'(busy), 64'd0);
    req = 1'b0; flush = 1'b0;

    // MULT flushed at counter=10
    req = 1'b1; op = 3'd0; op_a = 32'd5; op_b = 32'd9;
    tick();
    req = 1'b0;
    chk("flushcalc.busy0", 64'(busy), 64'd1);
    repeat (22) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushcalc.busy", 64'(busy), 64'd0);
    chk("flushcalc.done", 64'(done), 64'd0);
    chk("flushcalc.hi", 64'(hi), 64'h1234);
    tick();
    chk("flushcalc.done2", 64'(done), 64'd0);

    // Asynchronous reset mid-CALC
    req = 1'b1; op = 3'd0; op_a = 32'd7; op_b = 32'd6;
    tick();
    req = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.done", 64'(done), 64'd0);
    chk("arst.hi", 64'(hi), 64'd0);
    chk("arst.lo", 64'(lo), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 33);
    tick();
    chk("mult_neg.done_pulse", 64'(done), 64'd0);
    run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 33);
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
    run_op("divu_by0", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 33);
    run_op("div_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);

    // DIVU 9/4 with a stalled MFLO behind it
    req = 1'b1; op = 3'd3; op_a = 32'd9; op_b = 32'd4;
    tick();
    op = 3'd5;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      chk("divu_mflo.stall", 64'(stall), 64'd1);
      tick();
    end
    chk("divu_mflo.cycles", 64'(cyc), 64'd33);
    chk("divu_mflo.done", 64'(done), 64'd1);
    chk("divu_mflo.stall_end", 64'(stall), 64'd0);
    chk("divu_mflo.mf_data", 64'(mf_data), 64'd2);
    chk("divu_mflo.hi", 64'(hi), 64'd1);

    // Back-to-back start in the done cycle
    run_op("multu_early", 3'd1, 32'h0001_0000, 32'h0000_00FF, 32'h0, 32'h00FF_0000, EARLY_CYC);
    run_op("multu_full", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, 33);
    tick();
    chk("final.done", 64'(done), 64'd0);
    chk("final.busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
